// File: rtl/arb_switch.sv
// Round-robin multi-master bus switch with address decode,
// unmapped-address error and per-transaction timeout.
module arb_switch #(
  parameter int NMASTERS = 2,
  parameter int NSLAVES  = 4,
  parameter logic [32*NSLAVES-1:0] BASE_ADDR = '0,
  parameter logic [5*NSLAVES-1:0] ADDR_WIDTH =
    {NSLAVES{5'd8}},
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*NMASTERS-1:0] master_address,
  input  logic [32*NMASTERS-1:0] master_wdata,
  input  logic [4*NMASTERS-1:0]  master_wsel,
  input  logic [NMASTERS-1:0]    master_valid,
  output logic [31:0]            master_rdata,
  output logic [NMASTERS-1:0]    master_ready,
  output logic [NMASTERS-1:0]    master_error,
  output logic [31:0]            slave_address,
  output logic [31:0]            slave_wdata,
  output logic [3:0]             slave_wsel,
  output logic [NSLAVES-1:0]     slave_valid,
  input  logic [32*NSLAVES-1:0]  slave_rdata,
  input  logic [NSLAVES-1:0]     slave_ready,
  input  logic [NSLAVES-1:0]     slave_error
);

  localparam int GW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [GW-1:0] grant;
  logic [GW-1:0] rr_ptr;
  logic [TW-1:0] tcnt;

  int            gi;
  int            si;
  logic [31:0]   g_addr;
  logic [31:0]   g_wdata;
  logic [3:0]    g_wsel;
  logic          g_valid;
  logic          hit_any;
  logic [SW-1:0] sel;
  logic [31:0]   mask;
  logic          s_rdy;
  logic          s_err;
  logic          active;
  logic          timed_out;
  logic          resp;
  logic [GW-1:0] pick;
  logic [GW-1:0] pick_nxt;
  logic          found;

  assign gi = int'(grant);
  assign si = int'(sel);

  always_comb begin
    g_addr  = master_address[32*gi +: 32];
    g_wdata = master_wdata[32*gi +: 32];
    g_wsel  = master_wsel[4*gi +: 4];
    g_valid = master_valid[gi];
  end

  // Scan downward so the lowest-indexed hit is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    sel     = '0;
    mask    = '0;
    for (int k = NSLAVES - 1; k >= 0; k--) begin
      mask = 32'hFFFF_FFFF << ADDR_WIDTH[5*k +: 5];
      if (((g_addr ^ BASE_ADDR[32*k +: 32]) & mask) == 32'h0) begin
        hit_any = 1'b1;
        sel     = SW'(k);
      end
    end
  end

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NMASTERS; i++) begin
      if (!found && master_valid[(int'(rr_ptr) + i) % NMASTERS]) begin
        found = 1'b1;
        pick  = GW'((int'(rr_ptr) + i) % NMASTERS);
      end
    end
    pick_nxt = GW'((int'(pick) + 1) % NMASTERS);
  end

  assign s_rdy     = slave_ready[si];
  assign s_err     = slave_error[si];
  assign active    = (state == BUSY) && !rst && g_valid;
  assign timed_out = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT));
  assign resp      = hit_any && (s_rdy || s_err);

  assign slave_address = g_addr;
  assign slave_wdata   = g_wdata;
  assign slave_wsel    = g_wsel;
  assign master_rdata  = slave_rdata[32*si +: 32];

  // A response arriving on the timeout cycle still completes normally.
  always_comb begin
    slave_valid  = '0;
    master_ready = '0;
    master_error = '0;
    if (active) begin
      if (!hit_any) begin
        master_error[gi] = 1'b1;
      end else if (resp) begin
        slave_valid[si]  = 1'b1;
        master_ready[gi] = s_rdy;
        master_error[gi] = s_err;
      end else if (timed_out) begin
        master_error[gi] = 1'b1;
      end else begin
        slave_valid[si] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      tcnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (found) begin
            grant  <= pick;
            rr_ptr <= pick_nxt;
            state  <= BUSY;
          end
        end
        BUSY: begin
          tcnt <= tcnt + 1'b1;
          if (!g_valid || !hit_any || resp || timed_out) begin
            state <= IDLE;
            tcnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_switch.sv
// Directed bench for arb_switch: cycle table plus
// round-robin and reset-in-BUSY sequences.
module tb_arb_switch;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] master_address;
  logic [63:0] master_wdata;
  logic [7:0]  master_wsel;
  logic [1:0]  master_valid;
  logic [31:0] master_rdata;
  logic [1:0]  master_ready;
  logic [1:0]  master_error;
  logic [31:0] slave_address;
  logic [31:0] slave_wdata;
  logic [3:0]  slave_wsel;
  logic [3:0]  slave_valid;
  logic [127:0] slave_rdata;
  logic [3:0]  slave_ready;
  logic [3:0]  slave_error;

  always #5 clk = ~clk;

  arb_switch #(
    .NMASTERS(2),
    .NSLAVES(4),
    .BASE_ADDR({32'h4000_0000, 32'h2000_0000,
                32'h1000_0000, 32'h0000_0000}),
    .ADDR_WIDTH({4{5'd28}}),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_address(master_address),
    .master_wdata(master_wdata),
    .master_wsel(master_wsel),
    .master_valid(master_valid),
    .master_rdata(master_rdata),
    .master_ready(master_ready),
    .master_error(master_error),
    .slave_address(slave_address),
    .slave_wdata(slave_wdata),
    .slave_wsel(slave_wsel),
    .slave_valid(slave_valid),
    .slave_rdata(slave_rdata),
    .slave_ready(slave_ready),
    .slave_error(slave_error)
  );

  typedef struct {
    logic [1:0]  mv;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  w1;
    logic [3:0]  srdy;
    logic [3:0]  serr;
    logic [3:0]  sv;
    logic [1:0]  mr;
    logic [1:0]  me;
    logic [31:0] sa;
    logic [3:0]  ws;
    logic [31:0] rd;
  } vec_t;

  int tests = 0;
  int fails = 0;
  vec_t tbl[24];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [1:0] mv, input logic [31:0] a0,
    input logic [31:0] a1, input logic [3:0] w1,
    input logic [3:0] srdy, input logic [3:0] serr,
    input logic [3:0] sv, input logic [1:0] mr,
    input logic [1:0] me, input logic [31:0] sa,
    input logic [3:0] ws, input logic [31:0] rd);
    vec_t v;
    v.mv = mv; v.a0 = a0; v.a1 = a1; v.w1 = w1;
    v.srdy = srdy; v.serr = serr; v.sv = sv;
    v.mr = mr; v.me = me; v.sa = sa; v.ws = ws;
    v.rd = rd;
    return v;
  endfunction

  localparam logic [31:0] RAM = 32'h1000_0004;
  localparam logic [31:0] TMR = 32'h2000_0010;
  localparam logic [31:0] URT = 32'h4000_0008;
  localparam logic [31:0] RAM0 = 32'h1000_0000;
  localparam logic [31:0] NOMAP = 32'h3000_0000;
  localparam logic [31:0] RD1 = 32'hD000_0001;

  initial begin
    int got[$];
    tbl[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(2'b01, RAM, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(2'b01, RAM, 0, 0, 0, 0, 4'b0010, 0, 0, RAM, 0, 0);
    tbl[3]  = mk(2'b01, RAM, 0, 0, 4'b0010, 0, 4'b0010,
                 2'b01, 0, RAM, 0, RD1);
    tbl[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(2'b10, 0, NOMAP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(2'b10, 0, NOMAP, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0);
    tbl[7]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(2'b01, TMR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 9; i < 13; i++)
      tbl[i] = mk(2'b01, TMR, 0, 0, 0, 0, 4'b0100, 0, 0, TMR, 0, 0);
    tbl[13] = mk(2'b01, TMR, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0);
    tbl[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(2'b11, RAM0, URT, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(2'b11, RAM0, URT, 4'hF, 4'b0010, 4'b1000,
                 4'b1000, 0, 2'b10, URT, 4'hF, 0);
    tbl[17] = mk(2'b01, RAM0, URT, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(2'b01, RAM0, URT, 4'hF, 4'b0010, 0, 4'b0010,
                 2'b01, 0, RAM0, 0, RD1);
    tbl[19] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[20] = mk(2'b01, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(2'b01, 32'h100, 0, 0, 0, 0, 4'b0001, 0, 0,
                 32'h100, 0, 0);
    tbl[22] = mk(2'b00, 32'h100, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(2'b00, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    master_address = '0;
    master_wdata = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    master_wsel = '0;
    master_valid = '0;
    slave_rdata = {32'hD000_0003, 32'hD000_0002,
                   32'hD000_0001, 32'hD000_0000};
    slave_ready = '0;
    slave_error = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      master_valid   = tbl[i].mv;
      master_address = {tbl[i].a1, tbl[i].a0};
      master_wsel    = {tbl[i].w1, 4'h0};
      slave_ready    = tbl[i].srdy;
      slave_error    = tbl[i].serr;
      #3;
      chk($sformatf("row%0d sv", i), 32'(slave_valid), 32'(tbl[i].sv));
      chk($sformatf("row%0d mr", i), 32'(master_ready), 32'(tbl[i].mr));
      chk($sformatf("row%0d me", i), 32'(master_error), 32'(tbl[i].me));
      if (tbl[i].sv != 0) begin
        chk($sformatf("row%0d sa", i), slave_address, tbl[i].sa);
        chk($sformatf("row%0d ws", i), 32'(slave_wsel), 32'(tbl[i].ws));
      end
      if (tbl[i].mr != 0)
        chk($sformatf("row%0d rd", i), master_rdata, tbl[i].rd);
    end

    // Both masters hammer RAM; slave answers at once.
    @(posedge clk); #1;
    slave_ready = '0;
    master_valid = 2'b11;
    master_address = {32'h1000_0004, 32'h1000_0000};
    master_wsel = '0;
    for (int c = 0; c < 20 && got.size() < 4; c++) begin
      @(posedge clk); #1;
      slave_ready = slave_valid;
      #2;
      if (master_ready == 2'b01) got.push_back(0);
      else if (master_ready == 2'b10) got.push_back(1);
      else if (master_ready == 2'b11) got.push_back(9);
    end
    chk("rr count", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("rr order%0d", i), 32'(got[i]),
          (i % 2 == 0) ? 32'd1 : 32'd0);

    @(posedge clk); #1;
    slave_ready = '0;
    master_valid = '0;
    @(posedge clk); #1;
    master_valid = 2'b01;
    master_address = {32'h2000_0000, 32'h0000_0100};
    @(posedge clk); #1; #3;
    chk("pre-rst sv", 32'(slave_valid), 32'h1);
    rst = 1'b1;
    master_valid = 2'b11;
    #1;
    chk("in-rst sv", 32'(slave_valid), 32'h0);
    chk("in-rst pulses", 32'({master_ready, master_error}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #3;
    chk("post-rst sv", 32'(slave_valid), 32'h0);
    chk("post-rst pulses", 32'({master_ready, master_error}), 32'h0);
    @(posedge clk); #1; #3;
    chk("post-rst grant m0", 32'(slave_valid), 32'h1);
    chk("post-rst addr", slave_address, 32'h0000_0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
